// File: rtl/snap_intr_pkg.sv
// Shared types and helpers for the SNAP interrupt controller.
// Holds the FSM state encoding, default field widths and a constant log2 helper.
package snap_intr_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  localparam int INT_BITS_DEF = 3;
  localparam int SRC_W        = INT_BITS_DEF - 1;
  localparam int CTX_W        = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/snap_intr_ctrl_if.sv
// SNAP interrupt handshake: request with source/context, answered by a one-cycle ack.
// The controller drives the request side (master); the SNAP shell acknowledges (slave).
interface snap_intr_ctrl_if
  import snap_intr_pkg::*;
#(
  parameter int SRC_BITS     = SRC_W,
  parameter int CONTEXT_BITS = CTX_W
) ();

  logic                    interrupt;
  logic [SRC_BITS-1:0]     interrupt_src;
  logic [CONTEXT_BITS-1:0] interrupt_ctx;
  logic                    interrupt_ack;

  modport master (
    output interrupt,
    output interrupt_src,
    output interrupt_ctx,
    input  interrupt_ack
  );

  modport slave (
    input  interrupt,
    input  interrupt_src,
    input  interrupt_ctx,
    output interrupt_ack
  );

endinterface

// File: rtl/snap_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, wrapping.
// ptr must be below N.
module snap_rr_arb #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_vld
);

  logic [N-1:0] rot_s;
  int           idx_s;

  // Rotate so that bit 0 is the requester sitting at the pointer.
  assign rot_s = N'({req, req} >> ptr);

  // Scan from the far end so the last hit is the nearest one to the pointer.
  always_comb begin
    gnt_idx = {W{1'b0}};
    gnt_vld = 1'b0;
    idx_s   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx_s = int'(ptr) + k;
      if (idx_s >= N) begin
        idx_s = idx_s - N;
      end else begin
        idx_s = idx_s;
      end
      if (rot_s[k]) begin
        gnt_idx = W'(idx_s);
        gnt_vld = 1'b1;
      end else begin
        gnt_idx = gnt_idx;
        gnt_vld = gnt_vld;
      end
    end
  end

endmodule

// File: rtl/snap_intr_ctrl.sv
// Interrupt controller: per-source level/edge capture into pending bits, round-robin
// selection and a single outstanding request on the SNAP interrupt handshake.
module snap_intr_ctrl
  import snap_intr_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int INT_BITS     = 3,
  parameter int CONTEXT_BITS = 8,
  parameter int HOLDOFF_CYC  = 16
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  input  logic [NUM_SRC-1:0]              src_irq_i,
  input  logic [NUM_SRC-1:0]              cfg_enable_i,
  input  logic [NUM_SRC-1:0]              cfg_edge_i,
  input  logic [NUM_SRC*CONTEXT_BITS-1:0] cfg_ctx_i,
  input  logic                            cfg_ovf_clr_i,
  snap_intr_ctrl_if.master                snap,
  output logic [NUM_SRC-1:0]              pending_o,
  output logic [NUM_SRC-1:0]              ovf_o
);

  localparam int                IDX_W    = INT_BITS - 1;
  localparam int                HO_W     = clog2(HOLDOFF_CYC + 1);
  localparam logic [HO_W-1:0]   HO_LOAD  = HO_W'(HOLDOFF_CYC);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_SRC - 1);

  state_e                  state_r, state_s;
  logic [NUM_SRC-1:0]      src_q_r;
  logic [NUM_SRC-1:0]      pend_r, pend_s;
  logic [NUM_SRC-1:0]      ovf_r, ovf_s;
  logic [NUM_SRC-1:0]      ev_s, clr_s, dis_s;
  logic [IDX_W-1:0]        ptr_r, ptr_s;
  logic                    irq_r, irq_s;
  logic [IDX_W-1:0]        int_src_r, int_src_s;
  logic [CONTEXT_BITS-1:0] int_ctx_r, int_ctx_s;
  logic [CONTEXT_BITS-1:0] ctx_sel_s;
  logic [NUM_SRC-1:0]      arb_req_s;
  logic [IDX_W-1:0]        arb_idx_s;
  logic                    arb_vld_s;
  logic                    ack_s;

  // An ack only counts while a request is actually outstanding.
  assign ack_s = (state_r == REQ) & snap.interrupt_ack;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [HO_W-1:0] holdoff_r;
    logic            ho_zero_s;
    logic            granted_s;

    assign ho_zero_s = (holdoff_r == {HO_W{1'b0}});
    assign granted_s = (state_r == REQ) & (int_src_r == IDX_W'(gi));
    assign clr_s[gi] = ack_s & (int_src_r == IDX_W'(gi));

    // A level source being acked must not immediately re-pend; its holdoff starts now.
    assign ev_s[gi] = cfg_enable_i[gi] &
                      (cfg_edge_i[gi] ? (src_irq_i[gi] & ~src_q_r[gi])
                                      : (src_irq_i[gi] & ho_zero_s & ~clr_s[gi]));
    assign dis_s[gi]  = ~cfg_enable_i[gi] & ~granted_s;
    assign pend_s[gi] = ev_s[gi] | (pend_r[gi] & ~clr_s[gi] & ~dis_s[gi]);
    assign ovf_s[gi]  = (ev_s[gi] & cfg_edge_i[gi] & pend_r[gi]) |
                        (ovf_r[gi] & ~cfg_ovf_clr_i);

    // Level-mode re-arm delay, loaded on ack and counting down to zero.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        holdoff_r <= {HO_W{1'b0}};
      end else if (clr_s[gi] & ~cfg_edge_i[gi]) begin
        holdoff_r <= HO_LOAD;
      end else if (!ho_zero_s) begin
        holdoff_r <= holdoff_r - {{(HO_W-1){1'b0}}, 1'b1};
      end else begin
        holdoff_r <= holdoff_r;
      end
    end
  end

  // Disabled sources never compete, even while their pending bit drains.
  assign arb_req_s = pend_r & cfg_enable_i;

  snap_rr_arb #(
    .N (NUM_SRC),
    .W (IDX_W)
  ) u_arb (
    .req     (arb_req_s),
    .ptr     (ptr_r),
    .gnt_idx (arb_idx_s),
    .gnt_vld (arb_vld_s)
  );

  // Context of the source the arbiter is proposing.
  always_comb begin
    ctx_sel_s = {CONTEXT_BITS{1'b0}};
    for (int k = 0; k < NUM_SRC; k++) begin
      if (arb_idx_s == IDX_W'(k)) begin
        ctx_sel_s = cfg_ctx_i[k*CONTEXT_BITS +: CONTEXT_BITS];
      end else begin
        ctx_sel_s = ctx_sel_s;
      end
    end
  end

  // Request FSM: next state, request outputs and round-robin pointer.
  always_comb begin
    state_s   = state_r;
    irq_s     = irq_r;
    ptr_s     = ptr_r;
    int_src_s = int_src_r;
    int_ctx_s = int_ctx_r;
    case (state_r)
      IDLE: begin
        if (arb_vld_s) begin
          state_s   = REQ;
          irq_s     = 1'b1;
          int_src_s = arb_idx_s;
          int_ctx_s = ctx_sel_s;
        end else begin
          state_s = IDLE;
          irq_s   = 1'b0;
        end
      end
      REQ: begin
        if (snap.interrupt_ack) begin
          state_s = IDLE;
          irq_s   = 1'b0;
          ptr_s   = (int_src_r == LAST_IDX) ? {IDX_W{1'b0}}
                                            : int_src_r + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
          state_s = REQ;
          irq_s   = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        irq_s   = 1'b0;
      end
    endcase
  end

  // State, status and output registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r   <= IDLE;
      src_q_r   <= {NUM_SRC{1'b0}};
      pend_r    <= {NUM_SRC{1'b0}};
      ovf_r     <= {NUM_SRC{1'b0}};
      ptr_r     <= {IDX_W{1'b0}};
      irq_r     <= 1'b0;
      int_src_r <= {IDX_W{1'b0}};
      int_ctx_r <= {CONTEXT_BITS{1'b0}};
    end else begin
      state_r   <= state_s;
      src_q_r   <= src_irq_i;
      pend_r    <= pend_s;
      ovf_r     <= ovf_s;
      ptr_r     <= ptr_s;
      irq_r     <= irq_s;
      int_src_r <= int_src_s;
      int_ctx_r <= int_ctx_s;
    end
  end

  assign snap.interrupt     = irq_r;
  assign snap.interrupt_src = int_src_r;
  assign snap.interrupt_ctx = int_ctx_r;
  assign pending_o          = pend_r;
  assign ovf_o              = ovf_r;

endmodule

// File: tb/tb_snap_intr_ctrl.sv
// Self-checking bench for snap_intr_ctrl: scoreboard of expected grants plus
// per-scenario tasks covering arbitration, holdoff, overflow, disable and reset.
module tb_snap_intr_ctrl;

  logic       ap_clk = 1'b0;
  logic       ap_rst_n = 1'b0;
  logic [3:0] src_irq = 4'h0;
  logic [3:0] cfg_enable = 4'h0;
  logic [3:0] cfg_edge = 4'h0;
  logic [31:0] cfg_ctx = 32'h0;
  logic       cfg_ovf_clr = 1'b0;
  logic [3:0] pending;
  logic [3:0] ovf;

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] ctx;
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] ctx_tab [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

  snap_intr_ctrl_if intf ();

  snap_intr_ctrl dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .src_irq_i     (src_irq),
    .cfg_enable_i  (cfg_enable),
    .cfg_edge_i    (cfg_edge),
    .cfg_ctx_i     (cfg_ctx),
    .cfg_ovf_clr_i (cfg_ovf_clr),
    .snap          (intf),
    .pending_o     (pending),
    .ovf_o         (ovf)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic push_exp(input int s);
    exp_t e;
    e.src = 2'(s);
    e.ctx = ctx_tab[s];
    exp_q.push_back(e);
  endtask

  task automatic wait_grant();
    int   n;
    exp_t e;
    n = 0;
    while (intf.interrupt !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (intf.interrupt !== 1'b1) begin
      errors++;
      $display("FAIL grant_timeout: interrupt=%b, required 1", intf.interrupt);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_grant: src=%0d granted, none required", intf.interrupt_src);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (intf.interrupt_src !== e.src) begin
        errors++;
        $display("FAIL grant_src: got %0d, required %0d", intf.interrupt_src, e.src);
      end
      checks++;
      if (intf.interrupt_ctx !== e.ctx) begin
        errors++;
        $display("FAIL grant_ctx: got %h, required %h", intf.interrupt_ctx, e.ctx);
      end
    end
  endtask

  task automatic ack_req();
    intf.interrupt_ack = 1'b1;
    tick();
    intf.interrupt_ack = 1'b0;
    checks++;
    if (intf.interrupt !== 1'b0) begin
      errors++;
      $display("FAIL ack_drop: interrupt=%b, required 0", intf.interrupt);
    end
  endtask

  task automatic serve();
    wait_grant();
    ack_req();
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({intf.interrupt, intf.interrupt_src, intf.interrupt_ctx, pending, ovf} !== 19'h0) begin
      errors++;
      $display("FAIL reset_state: irq=%b src=%0d ctx=%h pend=%b ovf=%b, required all 0",
               intf.interrupt, intf.interrupt_src, intf.interrupt_ctx, pending, ovf);
    end
    ap_rst_n   = 1'b1;
    cfg_enable = 4'hF;
    cfg_edge   = 4'hF;
    tick();
    tick();
    checks++;
    if (intf.interrupt !== 1'b0 || pending !== 4'h0) begin
      errors++;
      $display("FAIL reset_idle: irq=%b pend=%b, required 0/0000", intf.interrupt, pending);
    end
  endtask

  task automatic test_round_robin();
    src_irq = 4'hF;
    tick();
    src_irq = 4'h0;
    checks++;
    if (pending !== 4'hF) begin
      errors++;
      $display("FAIL rr_all_pending: got %b, required 1111", pending);
    end
    for (int s = 0; s < 4; s++) push_exp(s);
    for (int s = 0; s < 4; s++) serve();
    checks++;
    if (pending !== 4'h0) begin
      errors++;
      $display("FAIL rr_drained: got %b, required 0000", pending);
    end
    src_irq = 4'b0010;
    tick();
    src_irq = 4'h0;
    push_exp(1);
    serve();
    src_irq = 4'hF;
    tick();
    src_irq = 4'h0;
    push_exp(2);
    push_exp(3);
    push_exp(0);
    push_exp(1);
    for (int s = 0; s < 4; s++) serve();
  endtask

  task automatic test_edge_single();
    src_irq[2] = 1'b1;
    tick();
    src_irq[2] = 1'b0;
    checks++;
    if (pending !== 4'b0100 || intf.interrupt !== 1'b0) begin
      errors++;
      $display("FAIL edge_pend: pend=%b irq=%b, required 0100/0", pending, intf.interrupt);
    end
    push_exp(2);
    tick();
    checks++;
    if (intf.interrupt !== 1'b1) begin
      errors++;
      $display("FAIL edge_latency: irq=%b, required 1", intf.interrupt);
    end
    wait_grant();
    ack_req();
    checks++;
    if (pending !== 4'h0) begin
      errors++;
      $display("FAIL edge_cleared: pend=%b, required 0000", pending);
    end
  endtask

  task automatic test_level_holdoff();
    logic early;
    cfg_edge[1] = 1'b0;
    src_irq[1]  = 1'b1;
    push_exp(1);
    serve();
    checks++;
    if (pending !== 4'h0) begin
      errors++;
      $display("FAIL level_ack_clear: pend=%b, required 0000", pending);
    end
    early = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (pending[1] !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL holdoff_quiet: re-pend seen within 16 cycles, required none");
    end
    tick();
    checks++;
    if (pending[1] !== 1'b1) begin
      errors++;
      $display("FAIL holdoff_rearm: pend[1]=%b on cycle 17, required 1", pending[1]);
    end
    push_exp(1);
    serve();
    repeat (5) tick();
    src_irq[1] = 1'b0;
    repeat (20) tick();
    checks++;
    if (pending !== 4'h0 || intf.interrupt !== 1'b0) begin
      errors++;
      $display("FAIL holdoff_drop: pend=%b irq=%b, required 0000/0", pending, intf.interrupt);
    end
    cfg_edge[1] = 1'b1;
  endtask

  task automatic test_overflow();
    src_irq[0] = 1'b1;
    tick();
    src_irq[0] = 1'b0;
    push_exp(0);
    wait_grant();
    src_irq[0] = 1'b1;
    tick();
    src_irq[0] = 1'b0;
    checks++;
    if (ovf !== 4'b0001) begin
      errors++;
      $display("FAIL ovf_set: got %b, required 0001", ovf);
    end
    tick();
    src_irq[0] = 1'b1;
    tick();
    src_irq[0] = 1'b0;
    checks++;
    if (ovf !== 4'b0001) begin
      errors++;
      $display("FAIL ovf_sticky: got %b, required 0001", ovf);
    end
    cfg_ovf_clr = 1'b1;
    tick();
    cfg_ovf_clr = 1'b0;
    checks++;
    if (ovf !== 4'h0) begin
      errors++;
      $display("FAIL ovf_clear: got %b, required 0000", ovf);
    end
    src_irq[0]         = 1'b1;
    intf.interrupt_ack = 1'b1;
    tick();
    intf.interrupt_ack = 1'b0;
    src_irq[0]         = 1'b0;
    checks++;
    if (intf.interrupt !== 1'b0 || pending[0] !== 1'b1 || ovf[0] !== 1'b1) begin
      errors++;
      $display("FAIL set_beats_ack: irq=%b pend0=%b ovf0=%b, required 0/1/1",
               intf.interrupt, pending[0], ovf[0]);
    end
    push_exp(0);
    serve();
    cfg_ovf_clr = 1'b1;
    tick();
    cfg_ovf_clr = 1'b0;
    checks++;
    if (ovf !== 4'h0 || pending !== 4'h0) begin
      errors++;
      $display("FAIL ovf_final: ovf=%b pend=%b, required 0000/0000", ovf, pending);
    end
  endtask

  task automatic test_disable();
    logic seen;
    src_irq[3] = 1'b1;
    tick();
    src_irq[3] = 1'b0;
    push_exp(3);
    wait_grant();
    cfg_enable[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (intf.interrupt !== 1'b1 || intf.interrupt_src !== 2'd3 || intf.interrupt_ctx !== ctx_tab[3]) begin
        errors++;
        $display("FAIL disable_hold: irq=%b src=%0d ctx=%h, required 1/3/%h",
                 intf.interrupt, intf.interrupt_src, intf.interrupt_ctx, ctx_tab[3]);
      end
    end
    ack_req();
    checks++;
    if (pending !== 4'h0) begin
      errors++;
      $display("FAIL disable_ack_clear: pend=%b, required 0000", pending);
    end
    cfg_enable = 4'hF;
    src_irq    = 4'b0011;
    tick();
    src_irq       = 4'h0;
    cfg_enable[1] = 1'b0;
    checks++;
    if (pending !== 4'b0011) begin
      errors++;
      $display("FAIL disable_both_pend: pend=%b, required 0011", pending);
    end
    push_exp(0);
    tick();
    checks++;
    if (pending !== 4'b0001) begin
      errors++;
      $display("FAIL disable_drop: pend=%b, required 0001", pending);
    end
    serve();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (intf.interrupt !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL disable_never_granted: src1 request seen, required none");
    end
    cfg_enable         = 4'hF;
    intf.interrupt_ack = 1'b1;
    tick();
    intf.interrupt_ack = 1'b0;
    tick();
    checks++;
    if (intf.interrupt !== 1'b0 || pending !== 4'h0) begin
      errors++;
      $display("FAIL stray_ack: irq=%b pend=%b, required 0/0000", intf.interrupt, pending);
    end
  endtask

  task automatic test_reset_mid();
    int extra;
    src_irq[2] = 1'b1;
    tick();
    src_irq[2] = 1'b0;
    push_exp(2);
    wait_grant();
    #2;
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if (intf.interrupt !== 1'b0 || pending !== 4'h0) begin
      errors++;
      $display("FAIL async_reset: irq=%b pend=%b, required 0/0000", intf.interrupt, pending);
    end
    src_irq[0] = 1'b1;
    tick();
    tick();
    ap_rst_n = 1'b1;
    push_exp(0);
    serve();
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (intf.interrupt === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || pending !== 4'h0) begin
      errors++;
      $display("FAIL reset_single_event: extra cycles=%0d pend=%b, required 0/0000", extra, pending);
    end
    src_irq = 4'h0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d grants outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    intf.interrupt_ack = 1'b0;
    cfg_ctx = {ctx_tab[3], ctx_tab[2], ctx_tab[1], ctx_tab[0]};
    test_reset();
    test_round_robin();
    test_edge_single();
    test_level_holdoff();
    test_overflow();
    test_disable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
